lsu: RTL and testbench

Load/store unit between the core's memory stage and the byte-addressable 64 KiB data memory. Decodes each access into data memory or memory-mapped I/O, generates byte masks and write strobes, and sign/zero-extends load data. Owns the I/O output registers (LEDs, 7-segment, LCD) and the input synchronisers (switches, buttons). Returns load data registered, one cycle after the request.

---
 rtl/lsu_pkg.sv | 71 +++++++
 rtl/lsu_ld_ext.sv | 29 ++
 rtl/lsu.sv | 160 ++++++++++++++++
 tb/tb_lsu.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: address map, funct3 codes,
// size masks and the region enum used by the decoder.
package lsu_pkg;

    // I/O pages, matched against addr[31:12]
    localparam logic [19:0] PG_LEDR  = 20'h10000;
    localparam logic [19:0] PG_LEDG  = 20'h10001;
    localparam logic [19:0] PG_HEXL  = 20'h10002;
    localparam logic [19:0] PG_HEXH  = 20'h10003;
    localparam logic [19:0] PG_LCD   = 20'h10004;
    localparam logic [19:0] PG_SW    = 20'h10010;
    localparam logic [19:0] PG_BTN   = 20'h10011;

    // RV32I width/sign codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Byte-lane masks before any lane shift
    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic [3:0] {
        REG_NONE,
        REG_DMEM,
        REG_LEDR,
        REG_LEDG,
        REG_HEXL,
        REG_HEXH,
        REG_LCD,
        REG_SW,
        REG_BTN
    } region_e;

    // Region from the upper 20 address bits; DMEM is the whole low 64 KiB.
    function automatic region_e decode_region(input logic [19:0] page);
        region_e r;
        r = REG_NONE;
        if (page[19:4] == 16'h0000) begin
            r = REG_DMEM;
        end else begin
            case (page)
                PG_LEDR: r = REG_LEDR;
                PG_LEDG: r = REG_LEDG;
                PG_HEXL: r = REG_HEXL;
                PG_HEXH: r = REG_HEXH;
                PG_LCD:  r = REG_LCD;
                PG_SW:   r = REG_SW;
                PG_BTN:  r = REG_BTN;
                default: r = REG_NONE;
            endcase
        end
        return r;
    endfunction

    // Size mask for a funct3 code; zero marks an invalid code.
    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        logic [3:0] m;
        case (f3)
            F3_LB, F3_LBU: m = MASK_B;
            F3_LH, F3_LHU: m = MASK_H;
            F3_LW:         m = MASK_W;
            default:       m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_ld_ext.sv
// Load data alignment: shift the selected word right by the byte lane, then
// sign- or zero-extend to 32 bits according to funct3.
module lsu_ld_ext
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = word >> {lane, 3'b000};

    // Extension per access width and signedness
    always_comb begin
        data = shifted;
        case (funct3)
            F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  data = {24'h000000, shifted[7:0]};
            F3_LHU:  data = {16'h0000, shifted[15:0]};
            F3_LW:   data = shifted;
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: decodes core accesses into data memory or memory-mapped
// I/O, drives the memory port, owns the I/O output registers and input
// synchronisers, and returns extended load data one cycle after the request.
//
// Request/response: i_lsu_wren / i_lsu_rden are single-cycle requests that
// are always accepted (no ready). The response for a request in cycle N is
// a one-cycle pulse in N+1: o_ld_valid for a completed load, o_misalign for
// a rejected access; neither pulses for a completed store. o_ld_data holds
// its value between loads.
module lsu
    import lsu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_st_data,
    input  logic [2:0]  i_funct3,
    input  logic        i_lsu_wren,
    input  logic        i_lsu_rden,
    output logic [31:0] o_ld_data,
    output logic        o_ld_valid,
    output logic        o_misalign,
    output logic [15:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    output logic        o_mem_wren,
    input  logic [31:0] i_mem_rdata,
    input  logic [31:0] i_io_sw,
    input  logic [3:0]  i_io_btn,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [55:0] o_io_hex,
    output logic [31:0] o_io_lcd
);

    region_e     region;
    logic [3:0]  mask;
    logic [1:0]  lane;
    logic        is_io;
    logic        f3_bad;
    logic        io_misalign;
    logic        reject;
    logic        io_wr;
    logic [3:0]  io_mask;
    logic [31:0] io_wdata;
    logic        ld_fire;
    logic [31:0] ld_word;
    logic [31:0] ld_ext_data;

    logic [31:0] sw_meta;
    logic [31:0] sw_sync;
    logic [3:0]  btn_meta;
    logic [3:0]  btn_sync;

    assign region = decode_region(i_lsu_addr[31:12]);
    assign mask   = size_mask(i_funct3);
    assign lane   = i_lsu_addr[1:0];
    assign is_io  = (region != REG_DMEM) && (region != REG_NONE);
    assign f3_bad = (mask == 4'b0000);

    // I/O registers are word-wide: halves must stay inside, words aligned.
    // DMEM handles unaligned accesses itself.
    assign io_misalign = is_io && (((mask == MASK_H) && i_lsu_addr[0]) ||
                                   ((mask == MASK_W) && (lane != 2'b00)));
    assign reject = f3_bad || io_misalign;

    // Memory port: data and mask stay lane-0 aligned; memory places them at addr.
    assign o_mem_addr  = i_lsu_addr[15:0];
    assign o_mem_wdata = i_st_data;
    assign o_mem_mask  = mask;
    assign o_mem_wren  = i_lsu_wren && (region == REG_DMEM) && !reject;

    // I/O strobes: shift mask and data up to the addressed lane.
    assign io_wr    = i_lsu_wren && is_io && !reject;
    assign io_mask  = mask << lane;
    assign io_wdata = i_st_data << {lane, 3'b000};

    // A store wins over a simultaneous load.
    assign ld_fire = i_lsu_rden && !i_lsu_wren && !reject;

    // Select the 32-bit word the load reads from
    always_comb begin
        ld_word = 32'h0000_0000;
        case (region)
            REG_DMEM: ld_word = i_mem_rdata;
            REG_LEDR: ld_word = o_io_ledr;
            REG_LEDG: ld_word = o_io_ledg;
            REG_HEXL: ld_word = {1'b0, o_io_hex[27:21], 1'b0, o_io_hex[20:14],
                                 1'b0, o_io_hex[13:7],  1'b0, o_io_hex[6:0]};
            REG_HEXH: ld_word = {1'b0, o_io_hex[55:49], 1'b0, o_io_hex[48:42],
                                 1'b0, o_io_hex[41:35], 1'b0, o_io_hex[34:28]};
            REG_LCD:  ld_word = o_io_lcd;
            REG_SW:   ld_word = sw_sync;
            REG_BTN:  ld_word = {28'h0000000, btn_sync};
            default:  ld_word = 32'h0000_0000;
        endcase
    end

    // Memory returns lane 0 at the address, so only I/O words need shifting.
    lsu_ld_ext u_ld_ext (
        .word   (ld_word),
        .lane   (is_io ? lane : 2'b00),
        .funct3 (i_funct3),
        .data   (ld_ext_data)
    );

    // I/O output registers, byte-lane writes; HEX keeps 7 bits per digit
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_io_ledr <= '0;
            o_io_ledg <= '0;
            o_io_hex  <= '0;
            o_io_lcd  <= '0;
        end else if (io_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (io_mask[b]) begin
                    case (region)
                        REG_LEDR: o_io_ledr[8*b +: 8]     <= io_wdata[8*b +: 8];
                        REG_LEDG: o_io_ledg[8*b +: 8]     <= io_wdata[8*b +: 8];
                        REG_LCD:  o_io_lcd[8*b +: 8]      <= io_wdata[8*b +: 8];
                        REG_HEXL: o_io_hex[7*b +: 7]      <= io_wdata[8*b +: 7];
                        REG_HEXH: o_io_hex[7*(b+4) +: 7]  <= io_wdata[8*b +: 7];
                        default:  ;
                    endcase
                end
            end
        end
    end

    // Two-flop synchronisers for the asynchronous switch and button inputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sw_meta  <= i_io_sw;
            sw_sync  <= sw_meta;
            btn_meta <= i_io_btn;
            btn_sync <= btn_meta;
        end
    end

    // Registered load result and response pulses
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_ld_data  <= '0;
            o_ld_valid <= 1'b0;
            o_misalign <= 1'b0;
        end else begin
            o_ld_valid <= ld_fire;
            o_misalign <= (i_lsu_wren || i_lsu_rden) && reject;
            if (ld_fire) begin
                o_ld_data <= ld_ext_data;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed cases plus random traffic, checked against a
// byte-level behavioural model through an expected-response queue.
module tb_lsu;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_st_data;
  logic [2:0]  i_funct3;
  logic        i_lsu_wren;
  logic        i_lsu_rden;
  logic [31:0] o_ld_data;
  logic        o_ld_valid;
  logic        o_misalign;
  logic [15:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        o_mem_wren;
  logic [31:0] mem_rdata;
  logic [31:0] i_io_sw;
  logic [3:0]  i_io_btn;
  logic [31:0] o_io_ledr;
  logic [31:0] o_io_ledg;
  logic [55:0] o_io_hex;
  logic [31:0] o_io_lcd;

  // clock / reset block
  always #5 clk = ~clk;

  lsu dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_lsu_addr  (i_lsu_addr),
    .i_st_data   (i_st_data),
    .i_funct3    (i_funct3),
    .i_lsu_wren  (i_lsu_wren),
    .i_lsu_rden  (i_lsu_rden),
    .o_ld_data   (o_ld_data),
    .o_ld_valid  (o_ld_valid),
    .o_misalign  (o_misalign),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_mask  (o_mem_mask),
    .o_mem_wren  (o_mem_wren),
    .i_mem_rdata (mem_rdata),
    .i_io_sw     (i_io_sw),
    .i_io_btn    (i_io_btn),
    .o_io_ledr   (o_io_ledr),
    .o_io_ledg   (o_io_ledg),
    .o_io_hex    (o_io_hex),
    .o_io_lcd    (o_io_lcd)
  );

  // data memory attached to the DUT port: lane k at addr+k, masked reads
  logic [7:0] mem [0:65535];

  always @(posedge clk) begin
    if (o_mem_wren)
      for (int k = 0; k < 4; k++)
        if (o_mem_mask[k]) mem[o_mem_addr + 16'(k)] <= o_mem_wdata[8*k +: 8];
  end

  always_comb begin
    mem_rdata = 32'h0;
    for (int k = 0; k < 4; k++)
      if (o_mem_mask[k]) mem_rdata[8*k +: 8] = mem[o_mem_addr + 16'(k)];
  end

  // reference model state
  logic [7:0]  ref_mem [0:65535];
  logic [31:0] m_ledr, m_ledg, m_lcd, m_ld;
  logic [6:0]  m_hex [8];
  logic [31:0] m_sw1, m_sw2;
  logic [3:0]  m_bt1, m_bt2;

  typedef struct packed {
    logic        v;
    logic        mis;
    logic [31:0] d;
    logic [31:0] ledr;
    logic [31:0] ledg;
    logic [55:0] hex;
    logic [31:0] lcd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic model_is_io(input logic [19:0] pg);
    return (pg == 20'h10000) || (pg == 20'h10001) || (pg == 20'h10002) ||
           (pg == 20'h10003) || (pg == 20'h10004) || (pg == 20'h10010) ||
           (pg == 20'h10011);
  endfunction

  function automatic logic [31:0] model_io_word(input logic [19:0] pg);
    logic [31:0] w;
    w = 32'h0;
    case (pg)
      20'h10000: w = m_ledr;
      20'h10001: w = m_ledg;
      20'h10002: w = {1'b0, m_hex[3], 1'b0, m_hex[2], 1'b0, m_hex[1], 1'b0, m_hex[0]};
      20'h10003: w = {1'b0, m_hex[7], 1'b0, m_hex[6], 1'b0, m_hex[5], 1'b0, m_hex[4]};
      20'h10004: w = m_lcd;
      20'h10010: w = m_sw2;
      20'h10011: w = {28'h0, m_bt2};
      default:   w = 32'h0;
    endcase
    return w;
  endfunction

  // monitor: one expected record per clock, checked just after the edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("ld_valid", 64'(o_ld_valid), 64'(mon_e.v));
      chk("misalign", 64'(o_misalign), 64'(mon_e.mis));
      chk("ld_data", 64'(o_ld_data), 64'(mon_e.d));
      chk("io_ledr", 64'(o_io_ledr), 64'(mon_e.ledr));
      chk("io_ledg", 64'(o_io_ledg), 64'(mon_e.ledg));
      chk("io_hex", 64'(o_io_hex), 64'(mon_e.hex));
      chk("io_lcd", 64'(o_io_lcd), 64'(mon_e.lcd));
    end
  end

  // driver: apply one cycle of stimulus, check the memory port, push expectations
  task automatic step(input logic rst, input logic wr, input logic rd,
                      input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    exp_t        e;
    int          nb;
    int          pos;
    logic        inv, io, dm, bad;
    logic [1:0]  ln;
    logic [19:0] pg;
    logic [31:0] raw, val, w;
    logic [7:0]  by;

    i_reset    = rst;
    i_lsu_wren = wr;
    i_lsu_rden = rd;
    i_lsu_addr = a;
    i_st_data  = d;
    i_funct3   = f3;
    #1;

    inv = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    nb  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    pg  = a[31:12];
    dm  = (a[31:16] == 16'h0);
    io  = model_is_io(pg);
    ln  = a[1:0];
    bad = inv || (io && (((nb == 2) && a[0]) || ((nb == 4) && (ln != 2'b00))));

    chk("mem_addr", 64'(o_mem_addr), 64'(a[15:0]));
    chk("mem_wren", 64'(o_mem_wren), 64'(wr && dm && !bad));
    if (!inv) chk("mem_mask", 64'(o_mem_mask), (nb == 1) ? 64'h1 : (nb == 2) ? 64'h3 : 64'hF);
    if (wr && dm && !bad) chk("mem_wdata", 64'(o_mem_wdata), 64'(d));

    // load value from the pre-edge model state
    raw = 32'h0;
    if (!bad) begin
      w = model_io_word(pg);
      for (int k = 0; k < nb; k++) begin
        if (dm) raw[8*k +: 8] = ref_mem[a[15:0] + 16'(k)];
        else if (io) raw[8*k +: 8] = w[8*(int'(ln) + k) +: 8];
      end
    end
    if (f3 == 3'b000) val = {{24{raw[7]}}, raw[7:0]};
    else if (f3 == 3'b001) val = {{16{raw[15]}}, raw[15:0]};
    else val = raw;

    // memory is not reset, so a DMEM store lands even under reset
    if (wr && dm && !bad)
      for (int k = 0; k < nb; k++) ref_mem[a[15:0] + 16'(k)] = d[8*k +: 8];

    if (rst) begin
      e.v = 1'b0;
      e.mis = 1'b0;
      m_ld = 0; m_ledr = 0; m_ledg = 0; m_lcd = 0;
      for (int i = 0; i < 8; i++) m_hex[i] = 7'h0;
      m_sw1 = 0; m_sw2 = 0; m_bt1 = 0; m_bt2 = 0;
    end else begin
      e.v   = rd && !wr && !bad;
      e.mis = (wr || rd) && bad;
      if (e.v) m_ld = val;
      if (wr && io && !bad) begin
        for (int k = 0; k < nb; k++) begin
          by  = d[8*k +: 8];
          pos = int'(ln) + k;
          case (pg)
            20'h10000: m_ledr[8*pos +: 8] = by;
            20'h10001: m_ledg[8*pos +: 8] = by;
            20'h10002: m_hex[pos] = by[6:0];
            20'h10003: m_hex[4 + pos] = by[6:0];
            20'h10004: m_lcd[8*pos +: 8] = by;
            default: ;
          endcase
        end
      end
      m_sw2 = m_sw1; m_sw1 = i_io_sw;
      m_bt2 = m_bt1; m_bt1 = i_io_btn;
    end

    e.d    = m_ld;
    e.ledr = m_ledr;
    e.ledg = m_ledg;
    e.lcd  = m_lcd;
    for (int i = 0; i < 8; i++) e.hex[7*i +: 7] = m_hex[i];
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
  endtask

  logic [19:0] pages [7];
  logic [31:0] ra;
  int          r;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    pages = '{20'h10000, 20'h10001, 20'h10002, 20'h10003, 20'h10004, 20'h10010, 20'h10011};
    i_reset = 1'b1; i_lsu_wren = 1'b0; i_lsu_rden = 1'b0;
    i_lsu_addr = 32'h0; i_st_data = 32'h0; i_funct3 = 3'b010;
    i_io_sw = 32'h0; i_io_btn = 4'h0;
    @(negedge clk);

    // reset state
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);

    // word store then load from DMEM
    step(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h1122_3344, 3'b010);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 3'b010);
    // byte store, signed and unsigned byte loads, unaligned DMEM half
    step(1'b0, 1'b1, 1'b0, 32'h0000_0203, 32'h0000_0080, 3'b000);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0203, 32'h0, 3'b000);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0203, 32'h0, 3'b100);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0101, 32'h0, 3'b001);
    idle();
    // LEDR half store at lane 2, misaligned half rejected, readback
    step(1'b0, 1'b1, 1'b0, 32'h1000_0002, 32'h0000_BEEF, 3'b001);
    step(1'b0, 1'b1, 1'b0, 32'h1000_0001, 32'h0000_1234, 3'b001);
    step(1'b0, 1'b0, 1'b1, 32'h1000_0000, 32'h0, 3'b010);
    step(1'b0, 1'b0, 1'b1, 32'h1000_0FF2, 32'h0, 3'b001);
    step(1'b0, 1'b0, 1'b1, 32'h1000_0002, 32'h0, 3'b010);
    // switch synchroniser latency
    i_io_sw = 32'hA5A5_0F0F;
    idle();
    idle();
    step(1'b0, 1'b0, 1'b1, 32'h1001_0000, 32'h0, 3'b010);
    i_io_sw = 32'h5A5A_F0F0;
    idle();
    step(1'b0, 1'b0, 1'b1, 32'h1001_0000, 32'h0, 3'b010);
    step(1'b0, 1'b0, 1'b1, 32'h1001_0000, 32'h0, 3'b010);
    // buttons
    i_io_btn = 4'hB;
    idle(); idle();
    step(1'b0, 1'b0, 1'b1, 32'h1001_1000, 32'h0, 3'b100);
    // HEX digits, both banks, bit 7 dropped
    step(1'b0, 1'b1, 1'b0, 32'h1000_2000, 32'h8F7F_0640, 3'b010);
    step(1'b0, 1'b1, 1'b0, 32'h1000_3003, 32'h0000_00FF, 3'b000);
    step(1'b0, 1'b0, 1'b1, 32'h1000_2000, 32'h0, 3'b010);
    // LCD and LEDG
    step(1'b0, 1'b1, 1'b0, 32'h1000_4000, 32'hCAFE_8001, 3'b010);
    step(1'b0, 1'b0, 1'b1, 32'h1000_4002, 32'h0, 3'b001);
    step(1'b0, 1'b1, 1'b0, 32'h1000_1001, 32'h0000_0077, 3'b000);
    // unmapped: store dropped, load returns 0 with valid
    step(1'b0, 1'b1, 1'b0, 32'h2000_0000, 32'hFFFF_FFFF, 3'b010);
    step(1'b0, 1'b0, 1'b1, 32'h2000_0000, 32'h0, 3'b010);
    // invalid funct3 on store and load
    step(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 3'b011);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 3'b111);
    // simultaneous store and load: store wins, then read it back
    step(1'b0, 1'b1, 1'b1, 32'h0000_0104, 32'h0BAD_F00D, 3'b010);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0104, 32'h0, 3'b010);
    // reset in the cycle after a load, and in the same cycle as a load
    step(1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 3'b010);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 3'b010);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0104, 32'h0, 3'b010);
    idle();

    // random traffic
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4) ra = 32'($urandom_range(0, 63));
      else if (r == 4) ra = 32'h0000_FFFC + 32'($urandom_range(0, 3));
      else if (r < 9) ra = {pages[$urandom_range(0, 6)], 12'($urandom_range(0, 4095))};
      else ra = 32'h2000_0000 | 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) i_io_sw = $urandom;
      if ($urandom_range(0, 7) == 0) i_io_btn = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 9);
      step(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ra, $urandom, (r > 7) ? 3'b010 : 3'(r));
    end

    idle();
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
